rng_share_arbiter: RTL and testbench

Shares one xorshift32 random-number generator among `N_REQ` sequence-evolution lanes. It seeds the generator from `seed_ID`, discards a fixed warm-up run, then grants one fresh 32-bit random word per cycle to requesters in round-robin order. It sits between the top-level `Schedule` controller, which supplies `seed_ID` and `seed_load`, and the per-lane mutation/substitution units that consume random draws.

---
 rtl/rng_share_arbiter.sv | 108 ++++++++++
 tb/tb_rng_share_arbiter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/rng_share_arbiter.sv
// rng_share_arbiter: one xorshift32 generator shared round-robin among N_REQ lanes (clk, reset, seed_ID, seed_load, req -> gnt, gnt_id, rnd_valid, rnd_data, state)
module rng_share_arbiter #(
  parameter int N_REQ       = 4,
  parameter int WARM_CYCLES = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               seed_ID,
  input  logic                     seed_load,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic                     rnd_valid,
  output logic [31:0]              rnd_data,
  output logic [2:0]               state
);
  localparam int IW = $clog2(N_REQ);
  typedef enum logic [2:0] {IDLE = 3'b000, SEED = 3'b001, WARM = 3'b010, SERVE = 3'b011} state_e;
  state_e            state_q, state_d;
  logic [31:0]       x_q, x_d, data_q, data_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [IW-1:0]     last_q, last_d, id_q, id_d, win, kk;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic              valid_q, valid_d, hit;
  int                k;
  function automatic logic [31:0] step(input logic [31:0] v);
    logic [31:0] t;
    t = v ^ (v << 13);
    t = t ^ (t >> 17);
    return t ^ (t << 5);
  endfunction
  // Scan from farthest offset down so the nearest requester after last wins.
  always_comb begin
    win = '0;
    hit = 1'b0;
    k   = 0;
    kk  = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      k  = (int'(last_q) + i) % N_REQ;
      kk = IW'(k);
      if (req[kk]) begin
        win = kk;
        hit = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    id_d    = id_q;
    data_d  = data_q;
    gnt_d   = '0;
    valid_d = 1'b0;
    if (seed_load) state_d = SEED;
    else begin
      unique case (state_q)
        IDLE: state_d = SEED;
        SEED: begin
          x_d     = {24'h5A5A5A, seed_ID};
          cnt_d   = '0;
          state_d = WARM;
        end
        WARM: begin
          x_d     = step(x_q);
          cnt_d   = cnt_q + 8'd1;
          state_d = (cnt_q == 8'(WARM_CYCLES - 1)) ? SERVE : WARM;
        end
        SERVE: if (hit) begin
          x_d        = step(x_q);
          data_d     = step(x_q);
          gnt_d[win] = 1'b1;
          id_d       = win;
          valid_d    = 1'b1;
          last_d     = win;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      cnt_q   <= '0;
      last_q  <= IW'(N_REQ - 1);
      id_q    <= '0;
      data_q  <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      id_q    <= id_d;
      data_q  <= data_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
    end
  end
  assign gnt       = gnt_q;
  assign gnt_id    = id_q;
  assign rnd_valid = valid_q;
  assign rnd_data  = data_q;
  assign state     = state_q;
endmodule

// File: tb/tb_rng_share_arbiter.sv
// tb_rng_share_arbiter: directed self-checking bench for rng_share_arbiter
module tb_rng_share_arbiter;
  logic        clk = 1'b0;
  logic        reset, seed_load;
  logic [7:0]  seed_ID;
  logic [3:0]  req, gnt;
  logic [1:0]  gnt_id;
  logic        rnd_valid;
  logic [31:0] rnd_data, mx, first0, first1;
  int          n_run = 0, n_fail = 0;
  rng_share_arbiter #(.N_REQ(4), .WARM_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .seed_ID(seed_ID), .seed_load(seed_load), .req(req),
    .gnt(gnt), .gnt_id(gnt_id), .rnd_valid(rnd_valid), .rnd_data(rnd_data), .state()
  );
  wire [2:0] st = dut.state;
  always #5 clk = ~clk;
  function automatic logic [31:0] xs(input logic [31:0] v);
    logic [31:0] a, b;
    a = v ^ {v[18:0], 13'd0};
    b = a ^ {17'd0, a[31:17]};
    return b ^ {b[26:0], 5'd0};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic chk_idle(input string tag, input logic [2:0] s);
    chk({tag, "_state"}, 32'(st), 32'(s));
    chk({tag, "_gnt"}, 32'(gnt), 32'd0);
    chk({tag, "_valid"}, 32'(rnd_valid), 32'd0);
  endtask
  // Expects SEED already showing (after seed_load) unless from_idle.
  task automatic boot(input bit from_idle, input logic [7:0] s);
    if (from_idle) tick;
    chk_idle("seed", 3'b001);
    mx = {24'h5A5A5A, s};
    for (int i = 0; i < 8; i++) begin
      tick;
      if (i == 0) seed_ID = ~s;
      chk_idle("warm", 3'b010);
      mx = xs(mx);
    end
    tick;
    chk_idle("serve0", 3'b011);
  endtask
  task automatic grant(input string tag, input logic [1:0] id);
    tick;
    mx = xs(mx);
    chk({tag, "_gnt"}, 32'(gnt), 32'(4'b0001 << id));
    chk({tag, "_id"}, 32'(gnt_id), 32'(id));
    chk({tag, "_valid"}, 32'(rnd_valid), 32'd1);
    chk({tag, "_data"}, rnd_data, mx);
  endtask
  initial begin
    logic [1:0] rr4 [8];
    logic [1:0] rr2 [4];
    logic [1:0] fair [6];
    rr4  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rr2  = '{2'd1, 2'd3, 2'd1, 2'd3};
    fair = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd2};
    reset = 1'b1; seed_load = 1'b0; seed_ID = 8'h00; req = 4'b0000;
    tick;
    chk_idle("rst", 3'b000);
    chk("rst_data", rnd_data, 32'd0);
    chk("rst_id", 32'(gnt_id), 32'd0);
    reset = 1'b0;
    boot(1'b1, 8'h00);
    req = 4'b0001;
    for (int i = 0; i < 16; i++) begin
      grant("det0", 2'd0);
      if (i == 0) first0 = mx;
    end
    req = 4'b0000;
    tick;
    chk_idle("noreq", 3'b011);
    chk("noreq_data", rnd_data, mx);
    req = 4'b1111;
    for (int i = 0; i < 8; i++) grant("rr4", rr4[i]);
    req = 4'b1010;
    for (int i = 0; i < 4; i++) grant("rr2", rr2[i]);
    for (int i = 0; i < 6; i++) begin
      req = (i < 3) ? 4'b0001 : 4'b0101;
      grant("fair", fair[i]);
    end
    req = 4'b1111; seed_ID = 8'h01; seed_load = 1'b1;
    tick;
    seed_load = 1'b0;
    chk("rsd_gnt", 32'(gnt), 32'd0);
    boot(1'b0, 8'h01);
    grant("rsd", 2'd3);
    first1 = mx;
    chk("rsd_differs", 32'(first1 != first0), 32'd1);
    reset = 1'b1; tick; reset = 1'b0; seed_ID = 8'h01;
    boot(1'b1, 8'h01);
    grant("boot1", 2'd0);
    chk("boot1_same", rnd_data, first1);
    for (int i = 1; i < 4; i++) grant("det1", rr4[i - 1]);
    req = 4'b0000; seed_ID = 8'h00;
    reset = 1'b1; tick; reset = 1'b0;
    for (int i = 0; i < 5; i++) tick;
    chk("mid_state", 32'(st), 32'b010);
    reset = 1'b1; seed_load = 1'b1; req = 4'b1111;
    tick;
    reset = 1'b0; seed_load = 1'b0;
    chk_idle("mwr", 3'b000);
    chk("mwr_data", rnd_data, 32'd0);
    chk("mwr_id", 32'(gnt_id), 32'd0);
    seed_ID = 8'h00;
    boot(1'b1, 8'h00);
    grant("mwr_first", 2'd0);
    chk("mwr_same", rnd_data, first0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
